// File: rtl/rf_dump_reader.sv
// Register-file dump engine: scans registers 0..NREG-1 through a spare read port and streams (index, value) beats.
// Optional build macro RF_DUMP_SKIP_ZERO_EN suppresses beats for zero registers (NREG-1 always emitted).
module rf_dump_reader #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  logic [1:0]    state;
  logic [AW-1:0] idx;
  logic [DW-1:0] cap;
  logic          skip;

  // $0 is hard-wired to zero regardless of what the read port returns
  assign cap = (idx == '0) ? '0 : rd_data;

`ifdef RF_DUMP_SKIP_ZERO_EN
  assign skip = (cap == '0) && (idx != LAST);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      idx      <= '0;
      out_idx  <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= READ;
            idx   <= '0;
          end
        end
        READ: begin
          if (abort) begin
            state <= IDLE;
          end else if (skip) begin
            idx <= idx + 1'b1;
          end else begin
            out_data <= cap;
            out_idx  <= idx;
            out_last <= (idx == LAST);
            state    <= SEND;
          end
        end
        SEND: begin
          // abort wins over a handshake on the same edge
          if (abort) begin
            state <= IDLE;
          end else if (out_ready) begin
            if (idx == LAST) begin
              state <= FIN;
            end else begin
              idx   <= idx + 1'b1;
              state <= READ;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_addr   = (state == READ) ? idx : '0;
    out_valid = (state == SEND);
    busy      = (state != IDLE);
    done      = (state == FIN) && !abort;
  end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Self-checking bench for rf_dump_reader: randomized backpressure/contents against a beat-list reference model.
module tb_rf_dump_reader;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;
`ifdef RF_DUMP_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] rd_addr, out_idx;
  logic [DW-1:0] rd_data, out_data;
  logic          out_valid, out_last, busy, done;

  logic [DW-1:0] rf     [NREG];
  logic [DW-1:0] shadow [NREG];
  logic          load = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_a = '0;
  logic [DW-1:0] wr_d = '0;

  int checks = 0;
  int passed = 0;

  logic [AW-1:0] exp_idx[$];
  logic [DW-1:0] exp_data[$];
  logic          exp_last[$];
  int            exp_cycles;

  logic [AW-1:0] obs_idx[$];
  logic [DW-1:0] obs_data[$];
  logic          obs_last[$];
  int            obs_sends[$];
  int            obs_unstable;

  rf_dump_reader #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Register file: bulk load or a single write port, both landing on the clock edge
  always @(posedge clk) begin
    if (load) rf <= shadow;
    else if (wr_en) rf[wr_a] <= wr_d;
  end
  assign rd_data = rf[rd_addr];

  task automatic load_rf();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < NREG; i++) shadow[i] = 32'(i) * 32'h1111_1111;
    load_rf();
  endtask

  task automatic fill_random();
    for (int i = 0; i < NREG; i++) shadow[i] = ($urandom_range(3) == 0) ? '0 : $urandom;
  endtask

  // Expected beat list: every register in order, $0 reads as zero, zeros dropped when skipping
  function automatic void build_model();
    int nskip = 0;
    logic [DW-1:0] v;
    exp_idx.delete(); exp_data.delete(); exp_last.delete();
    for (int i = 0; i < NREG; i++) begin
      v = (i == 0) ? '0 : shadow[i];
      if (SKIP && v == '0 && i != NREG - 1) nskip++;
      else begin
        exp_idx.push_back(AW'(i));
        exp_data.push_back(v);
        exp_last.push_back(i == NREG - 1);
      end
    end
    exp_cycles = nskip + 2 * exp_idx.size() + 1;
  endfunction

  task automatic run_scan(input int ready_pct, input int hold_idx, input int hold_n,
                          input int wr_idx, input logic [DW-1:0] wr_val,
                          input int start_again_k, input int stop_idx,
                          output int done_k, output bit stopped);
    int held = 0;
    int sends = 0;
    bit wrote = 0;
    logic [AW-1:0] ci = '0;
    logic [DW-1:0] cd = '0;
    obs_idx.delete(); obs_data.delete(); obs_last.delete(); obs_sends.delete();
    obs_unstable = 0; done_k = -1; stopped = 0;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      start = (k == start_again_k);
      wr_en = 1'b0;
      if (done) begin done_k = k; break; end
      if (out_valid) begin
        if (stop_idx >= 0 && int'(out_idx) == stop_idx) begin stopped = 1; break; end
        if (sends == 0) begin ci = out_idx; cd = out_data; end
        else if (out_idx !== ci || out_data !== cd) obs_unstable++;
        sends++;
        if (int'(out_idx) == hold_idx) begin
          out_ready = (held >= hold_n);
          held++;
        end else out_ready = ($urandom_range(99) < ready_pct);
        if (out_ready) begin
          obs_idx.push_back(out_idx); obs_data.push_back(out_data);
          obs_last.push_back(out_last); obs_sends.push_back(sends);
          sends = 0;
        end
      end else begin
        out_ready = 1'($urandom_range(1));
        if (wr_idx >= 0 && !wrote && busy && int'(rd_addr) == wr_idx) begin
          wr_en = 1'b1; wr_a = AW'(wr_idx); wr_d = wr_val;
          shadow[wr_idx] = wr_val; wrote = 1;
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    fill_pattern();
    #1 rstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_idx, out_data, out_last, busy, done, rd_addr} !== '0)
      $display("FAIL reset_outputs: got valid=%b idx=%0d data=%h last=%b busy=%b done=%b rd_addr=%0d, want all 0",
               out_valid, out_idx, out_data, out_last, busy, done, rd_addr);
    else passed++;
    #2 rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_full_scan();
    int dk; bit st;
    fill_pattern();
    build_model();
    run_scan(100, -1, 0, -1, '0, -1, -1, dk, st);
    checks++;
    if (dk !== exp_cycles) $display("FAIL full_done_cycle: got %0d want %0d", dk, exp_cycles); else passed++;
    checks++;
    if (busy !== 1'b1) $display("FAIL full_busy_at_done: got %b want 1", busy); else passed++;
    checks++;
    if (obs_idx.size() != exp_idx.size())
      $display("FAIL full_beat_count: got %0d want %0d", obs_idx.size(), exp_idx.size());
    else passed++;
    for (int i = 0; i < exp_idx.size() && i < obs_idx.size(); i++) begin
      checks++;
      if (obs_idx[i] !== exp_idx[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i])
        $display("FAIL full_beat %0d: got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                 i, obs_idx[i], obs_data[i], obs_last[i], exp_idx[i], exp_data[i], exp_last[i]);
      else passed++;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL full_after_done: busy=%b done=%b want 0 0", busy, done);
    else passed++;
  endtask

  task automatic test_backpressure();
    int dk; bit st; int pos = -1;
    fill_pattern();
    build_model();
    run_scan(70, 7, 3, -1, '0, -1, -1, dk, st);
    checks++;
    if (obs_unstable != 0) $display("FAIL bp_stable: got %0d changes while stalled want 0", obs_unstable);
    else passed++;
    checks++;
    if (obs_idx.size() != exp_idx.size())
      $display("FAIL bp_beat_count: got %0d want %0d", obs_idx.size(), exp_idx.size());
    else passed++;
    for (int i = 0; i < exp_idx.size() && i < obs_idx.size(); i++) begin
      if (obs_idx[i] == 7) pos = i;
      checks++;
      if (obs_idx[i] !== exp_idx[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i])
        $display("FAIL bp_beat %0d: got idx=%0d data=%h want idx=%0d data=%h",
                 i, obs_idx[i], obs_data[i], exp_idx[i], exp_data[i]);
      else passed++;
    end
    checks++;
    if (pos < 0 || obs_sends[pos] != 4 || obs_data[pos] !== 32'h7777_7777)
      $display("FAIL bp_idx7_hold: found=%0d send_cycles=%0d want 4 data 77777777",
               pos, (pos < 0) ? 0 : obs_sends[pos]);
    else passed++;
    checks++;
    if (dk < exp_cycles) $display("FAIL bp_done: got cycle %0d want >= %0d", dk, exp_cycles); else passed++;
  endtask

  task automatic test_random();
    int dk; bit st;
    for (int r = 0; r < 3; r++) begin
      fill_random();
      load_rf();
      build_model();
      run_scan(50, -1, 0, -1, '0, -1, -1, dk, st);
      checks++;
      if (dk < 0 || obs_idx.size() != exp_idx.size())
        $display("FAIL rand_count r%0d: got %0d beats done_k=%0d want %0d", r, obs_idx.size(), dk, exp_idx.size());
      else passed++;
      for (int i = 0; i < exp_idx.size() && i < obs_idx.size(); i++) begin
        checks++;
        if (obs_idx[i] !== exp_idx[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i])
          $display("FAIL rand_beat r%0d/%0d: got idx=%0d data=%h want idx=%0d data=%h",
                   r, i, obs_idx[i], obs_data[i], exp_idx[i], exp_data[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_coherency();
    int dk; bit st;
    logic [DW-1:0] got9;
    fill_pattern();
    build_model();
    run_scan(100, -1, 0, 9, 32'hDEAD_BEEF, -1, -1, dk, st);
    got9 = 'x;
    foreach (obs_idx[i]) if (obs_idx[i] == 9) got9 = obs_data[i];
    checks++;
    if (got9 !== 32'h9999_9999) $display("FAIL coh_old_value: got %h want 99999999", got9); else passed++;
    build_model();
    run_scan(100, -1, 0, -1, '0, -1, -1, dk, st);
    got9 = 'x;
    foreach (obs_idx[i]) if (obs_idx[i] == 9) got9 = obs_data[i];
    checks++;
    if (got9 !== 32'hDEAD_BEEF) $display("FAIL coh_new_value: got %h want deadbeef", got9); else passed++;
  endtask

  task automatic test_abort();
    int dk; bit st; int npre = 0;
    fill_random();
    shadow[12] = shadow[12] | 32'h1;
    load_rf();
    build_model();
    run_scan(100, -1, 0, -1, '0, -1, 12, dk, st);
    abort = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (!st || busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_idle: reached=%b busy=%b valid=%b done=%b want 1 0 0 0", st, busy, out_valid, done);
    else passed++;
    foreach (exp_idx[i]) if (exp_idx[i] < 12) npre++;
    checks++;
    if (obs_idx.size() != npre) $display("FAIL abort_beats: got %0d want %0d", obs_idx.size(), npre);
    else passed++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_no_done c%0d: done=%b busy=%b", c, done, busy);
      else passed++;
    end
    run_scan(100, -1, 0, -1, '0, -1, -1, dk, st);
    checks++;
    if (obs_idx.size() == 0 || obs_idx[0] !== exp_idx[0] || dk != exp_cycles)
      $display("FAIL abort_restart: beats=%0d done_k=%0d want first idx %0d done_k %0d",
               obs_idx.size(), dk, exp_idx[0], exp_cycles);
    else passed++;
  endtask

  task automatic test_busy_start_reset();
    int dk; bit st; int npre = 0;
    fill_random();
    shadow[20] = shadow[20] | 32'h1;
    load_rf();
    build_model();
    run_scan(100, -1, 0, -1, '0, 10, 20, dk, st);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (!st || {out_valid, out_idx, out_data, out_last, busy, done, rd_addr} !== '0)
      $display("FAIL rst_midscan: reached=%b valid=%b idx=%0d data=%h busy=%b want all 0",
               st, out_valid, out_idx, out_data, busy);
    else passed++;
    foreach (exp_idx[i]) if (exp_idx[i] < 20) npre++;
    checks++;
    if (obs_idx.size() != npre) $display("FAIL rst_prefix_count: got %0d want %0d", obs_idx.size(), npre);
    else passed++;
    for (int i = 0; i < npre && i < obs_idx.size(); i++) begin
      checks++;
      if (obs_idx[i] !== exp_idx[i] || obs_data[i] !== exp_data[i])
        $display("FAIL rst_prefix_beat %0d: got idx=%0d data=%h want idx=%0d data=%h",
                 i, obs_idx[i], obs_data[i], exp_idx[i], exp_data[i]);
      else passed++;
    end
    @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_quiet c%0d: valid=%b busy=%b", c, out_valid, busy);
      else passed++;
    end
  endtask

  task automatic test_skip_zero();
    int dk; bit st;
    for (int i = 0; i < NREG; i++) shadow[i] = '0;
    shadow[3] = 32'hA;
    load_rf();
    build_model();
    run_scan(100, -1, 0, -1, '0, -1, -1, dk, st);
    checks++;
    if (dk !== exp_cycles) $display("FAIL skip_done_cycle: got %0d want %0d", dk, exp_cycles); else passed++;
    checks++;
    if (obs_idx.size() != exp_idx.size())
      $display("FAIL skip_beat_count: got %0d want %0d", obs_idx.size(), exp_idx.size());
    else passed++;
    for (int i = 0; i < exp_idx.size() && i < obs_idx.size(); i++) begin
      checks++;
      if (obs_idx[i] !== exp_idx[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i])
        $display("FAIL skip_beat %0d: got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                 i, obs_idx[i], obs_data[i], obs_last[i], exp_idx[i], exp_data[i], exp_last[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_backpressure();
    test_random();
    test_coherency();
    test_abort();
    test_busy_start_reset();
    test_skip_zero();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rf_dump_reader.md
# rf_dump_reader

Debug readout engine for the 32×32 CPU register file. It shares a combinational read port with decode, scans registers 0..31 on request, and streams each (index, value) pair out over a valid/ready handshake. The testbench monitor or UART debug bridge uses it, which replaces per-cycle register printing. It only reads: the write path (`RFWr`, `A3`, `WD`) is untouched.

## Interface
- `NREG`, 32: number of registers scanned. Must be a power of two and at least 2.
- `AW`, 5: address width, equal to log2(`NREG`).
- `DW`, 32: register data width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `start`  in  1  request a dump. Sampled only in IDLE.
- `abort`  in  1  cancel the dump in progress.
- `rd_addr`  out  AW  register-file read address, wired to a spare read port.
- `rd_data`  in  DW  combinational read data for `rd_addr`, valid in the same cycle.
- `out_valid`  out  1  an output beat is present.
- `out_ready`  in  1  the consumer accepts the beat.
- `out_idx`  out  AW  register index of the beat.
- `out_data`  out  DW  register value of the beat.
- `out_last`  out  1  the beat carries index NREG-1.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when a scan completes normally.

## Operation
- States are IDLE, READ, SEND and FIN.
- **IDLE**
  - `start`=1 → READ, and the index counter `idx` is cleared to 0.
  - `start` in any other state is ignored; it is not queued.
- **READ**
  - `rd_addr`=`idx`.
  - On the clock edge, `out_data` ← `rd_data`, except that `out_data` ← 0 when `idx`=0 because $0 is hard-wired to zero.
  - `out_idx` ← `idx`. Next state is SEND.
- **SEND**
  - `out_valid`=1.
  - `out_data`, `out_idx` and `out_last` are held stable while `out_ready`=0.
  - When `out_valid`&&`out_ready`: if `idx`=NREG-1, go to FIN; otherwise `idx`+1 and go to READ.
- **FIN**
  - `done`=1 for this cycle, then IDLE.
- **abort**
  - `abort`=1 in READ, SEND or FIN → IDLE on the next edge.
  - `out_valid` drops even without a handshake, and `done` is not pulsed.
  - `abort` has priority over a simultaneous handshake.
- **Coherency**
  - Each register is sampled in its own READ cycle; the dump is not an atomic snapshot.
  - A write to register k that lands on the same edge as READ of k is not seen, because the old value is captured.
- `rd_addr` is 0 outside READ.
- `idx` never wraps: the scan ends at NREG-1.

## Timing
- Reset values: state=IDLE, `idx`=0, `rd_addr`=0, `out_valid`=0, `out_idx`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0.
- `start` sampled at edge T → READ during cycle T+1, first `out_valid` in cycle T+2.
- Each register costs one READ cycle plus one or more SEND cycles.
- With `out_ready` tied high, a full scan takes 2·NREG cycles from the first READ to the last accept; `done` follows one cycle after the last accept.
- `busy` is high from the cycle after `start` through the FIN cycle inclusive.
- Reset asserted mid-scan clears everything asynchronously, including an in-flight beat. After reset release, a new `start` is required.

## Configuration
- `RF_DUMP_SKIP_ZERO_EN`
  - **Defined:** in READ, if the captured value is 0 and `idx`≠NREG-1, no beat is emitted: `idx`+1 and the state stays in READ. A zero register costs one cycle. Index 0 is therefore always skipped, while NREG-1 is always emitted so `out_last` always appears.
  - **Undefined:** every register, including zeros, produces a beat.

## Test plan
- Reset with `rf[i]`=i·0x11111111, pulse `start`, `out_ready`=1 → 32 beats with `out_idx` 0..31 and `out_data`[0]=0, `out_data`[5]=0x55555555. `out_last` is high only on idx 31, `done` is high 65 cycles after `start`, `busy` falls with `done`.
- Same contents with `out_ready` low for 3 cycles at idx 7 → `out_data`=0x77777777 and `out_idx`=7 held for all 4 SEND cycles, with no duplicate or dropped beat.
- `rf[9]` written with 0xDEADBEEF on the edge where READ idx=9, old value 0x99999999 → the beat for idx 9 carries 0x99999999. A second dump shows 0xDEADBEEF.
- `abort` during SEND at idx 12 with `out_ready`=1 → no beat is accepted for idx 12, the block returns to IDLE next cycle, and `done` stays 0. A new `start` restarts at idx 0.
- `start` pulsed while busy, and `rstn` dropped at idx 20 → the extra `start` has no effect. Reset returns all outputs to 0 within the same cycle, with no further beats until the next `start`.
- With `RF_DUMP_SKIP_ZERO_EN`, only `rf[3]`=0xA and `rf[31]`=0 nonzero-set, i.e. `rf[31]` is 0 → beats are exactly idx 3 (0xA) and idx 31 (0, `out_last`=1), and `done` follows.
